// File: rtl/fsm_dispatcher_pkg.sv
// Shared definitions for the Control Unit dispatcher: state encoding,
// instruction class indices and the default watchdog limit.
package fsm_dispatcher_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    DISPATCH = 3'd3,
    WAIT     = 3'd4,
    TRAP     = 3'd5,
    FAULT    = 3'd6
  } state_t;

  localparam int CLS_ALU = 0;
  localparam int CLS_MEM = 1;
  localparam int CLS_BRJ = 2;
  localparam int CLS_FPU = 3;

  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/fsm_dispatcher_if.sv
// Fetch and start/done handshake between the dispatcher (master) and the
// memory port plus execution FSMs (slave).
interface fsm_dispatcher_if #(
  parameter int N_FSM = 4,
  parameter int IDX_W = 2
);
  logic             imem_start;
  logic             imem_done;
  logic             load_insn;
  logic [N_FSM-1:0] fsm_class;
  logic [N_FSM-1:0] fsm_done;
  logic [N_FSM-1:0] fsm_start;
  logic [IDX_W-1:0] fsm_idx;

  modport master (
    output imem_start, load_insn, fsm_start, fsm_idx,
    input  imem_done, fsm_class, fsm_done
  );

  modport slave (
    input  imem_start, load_insn, fsm_start, fsm_idx,
    output imem_done, fsm_class, fsm_done
  );
endinterface

// File: rtl/fsm_dispatcher_onehot_enc.sv
// One-hot to binary encoder; valid only when exactly one input bit is set.
module fsm_dispatcher_onehot_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) idx = idx | W'(i);
    end
    valid = (vec != '0) && ((vec & (vec - N'(1))) == '0);
  end

endmodule

// File: rtl/fsm_dispatcher.sv
// Control Unit sequencer: fetch, decode wait, one-hot dispatch to an execution
// FSM, completion wait with watchdog, plus illegal/fault trapping and instret.
module fsm_dispatcher
  import fsm_dispatcher_pkg::*;
#(
  parameter int N_FSM   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int IDX_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  fsm_dispatcher_if.master    bus,
  output logic                busy,
  output logic                illegal,
  output logic                fault,
  output logic [63:0]         instret
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t           state;
  logic [WD_W-1:0]  wd;
  logic [IDX_W-1:0] cls_idx;
  logic             cls_valid;
  logic [N_FSM-1:0] exp_mask;
  logic             hit;
  logic             stray;

  fsm_dispatcher_onehot_enc #(.N(N_FSM), .W(IDX_W)) u_enc (
    .vec   (bus.fsm_class),
    .idx   (cls_idx),
    .valid (cls_valid)
  );

  always_comb begin
    exp_mask              = '0;
    exp_mask[bus.fsm_idx] = 1'b1;
    hit                   = (bus.fsm_done & exp_mask) != '0;
    stray                 = (bus.fsm_done & ~exp_mask) != '0;
  end

  // Outputs are registered alongside the state, so each pulse is high for
  // exactly the first cycle of the state entered on that transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wd             <= '0;
      bus.imem_start <= 1'b0;
      bus.load_insn  <= 1'b0;
      bus.fsm_start  <= '0;
      bus.fsm_idx    <= '0;
      busy           <= 1'b0;
      illegal        <= 1'b0;
      fault          <= 1'b0;
      instret        <= '0;
    end else begin
      bus.imem_start <= 1'b0;
      bus.load_insn  <= 1'b0;
      bus.fsm_start  <= '0;
      case (state)
        IDLE: begin
          if (run) begin
            state          <= FETCH;
            bus.imem_start <= 1'b1;
            busy           <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.imem_done) begin
            state         <= DECODE;
            bus.load_insn <= 1'b1;
          end
        end
        DECODE: state <= DISPATCH;
        DISPATCH: begin
          if (cls_valid) begin
            state         <= WAIT;
            bus.fsm_start <= bus.fsm_class;
            bus.fsm_idx   <= cls_idx;
            wd            <= '0;
          end else begin
            state   <= TRAP;
            illegal <= 1'b1;
            busy    <= 1'b0;
          end
        end
        WAIT: begin
          // A foreign done bit outranks the expected one; done outranks timeout.
          if (stray) begin
            state <= FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
          end else if (hit) begin
            instret <= instret + 64'd1;
            if (run) begin
              state          <= FETCH;
              bus.imem_start <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (wd == WD_LAST) begin
            state <= FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule
